// File: rtl/btn_cond_pkg.sv
// Shared definitions for the push-button conditioner.
//   btn_state_e : per-channel debounce FSM state (2 bits)
//   cnt_width   : counter width able to hold the largest cycle count without wrapping
package btn_cond_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressWait   = 2'd1,
    StPressed     = 2'd2,
    StReleaseWait = 2'd3
  } btn_state_e;

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: input synchroniser, debounce FSM and optional auto-repeat.
// Optional feature macro: BTN_AUTO_REPEAT_EN (repeat pulses while the button is held).
// Ports:
//   clk       in  system clock
//   rst       in  asynchronous reset, active-high
//   i_btn     in  raw asynchronous button level, 1 = pressed
//   o_pulse   out one-cycle pulse per accepted press (and per repeat when enabled)
//   o_level   out debounced level
//   o_release out one-cycle pulse per accepted release
module btn_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_START    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_pulse,
  output logic o_level,
  output logic o_release
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_START, REPEAT_PERIOD);
  localparam logic [CW-1:0] DebLast = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  btn_state_e             r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_pulse;
  logic                   r_level;
  logic                   r_release;
  logic                   w_s;
  logic                   w_rep_hit;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_btn};
    end
  end

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CW-1:0] RepStartLast  = CW'(REPEAT_START - 1);
  localparam logic [CW-1:0] RepPeriodLast = CW'(REPEAT_PERIOD - 1);

  logic [CW-1:0] r_rcnt;
  logic          r_rfirst;  // still waiting for the first repeat after the press

  assign w_rep_hit = (r_state == StPressed) && w_s &&
                     (r_rcnt == (r_rfirst ? RepStartLast : RepPeriodLast));

  // Runs only while steadily held in PRESSED; any excursion restarts the start delay.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end else if ((r_state == StPressed) && w_s) begin
      if (w_rep_hit) begin
        r_rcnt   <= '0;
        r_rfirst <= 1'b0;
      end else begin
        r_rcnt <= r_rcnt + CW'(1);
      end
    end else begin
      r_rcnt   <= '0;
      r_rfirst <= 1'b1;
    end
  end
`else
  assign w_rep_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StReleased;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_level   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      unique case (r_state)
        StReleased: begin
          if (w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state <= StPressed;
              r_level <= 1'b1;
              r_pulse <= 1'b1;
              r_cnt   <= '0;
            end else begin
              r_state <= StPressWait;
              r_cnt   <= CW'(1);
            end
          end
        end
        StPressWait: begin
          if (!w_s) begin
            r_state <= StReleased;
            r_cnt   <= '0;
          end else if (r_cnt == DebLast) begin
            r_state <= StPressed;
            r_level <= 1'b1;
            r_pulse <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StPressed: begin
          if (!w_s) begin
            if (DEBOUNCE_CYCLES == 1) begin
              r_state   <= StReleased;
              r_level   <= 1'b0;
              r_release <= 1'b1;
              r_cnt     <= '0;
            end else begin
              r_state <= StReleaseWait;
              r_cnt   <= CW'(1);
            end
          end else if (w_rep_hit) begin
            r_pulse <= 1'b1;
          end
        end
        StReleaseWait: begin
          if (w_s) begin
            r_state <= StPressed;
            r_cnt   <= '0;
          end else if (r_cnt == DebLast) begin
            r_state   <= StReleased;
            r_level   <= 1'b0;
            r_release <= 1'b1;
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= StReleased;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_pulse   = r_pulse;
  assign o_level   = r_level;
  assign o_release = r_release;

endmodule

// File: rtl/btn_pulse_conditioner.sv
// N-channel push-button front end: each channel synchronised, debounced and turned into
// press/release pulses plus a debounced level. Channels are fully independent.
// Optional feature macro: BTN_AUTO_REPEAT_EN (auto-repeat press pulses while held).
// Ports:
//   clk         in  system clock
//   rst         in  asynchronous reset, active-high
//   btn_in      in  [NUM_BTN] raw button levels, 1 = pressed
//   btn_pulse   out [NUM_BTN] one-cycle press (and repeat) pulses
//   btn_level   out [NUM_BTN] debounced levels
//   btn_release out [NUM_BTN] one-cycle release pulses
module btn_pulse_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned NUM_BTN         = 2,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned REPEAT_START    = 5000000,
  parameter int unsigned REPEAT_PERIOD   = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_pulse,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
    btn_channel #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_START   (REPEAT_START),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .i_btn    (btn_in[g]),
      .o_pulse  (btn_pulse[g]),
      .o_level  (btn_level[g]),
      .o_release(btn_release[g])
    );
  end

endmodule
